// File: rtl/conv_pe_acc.sv
// conv_pe_acc -- convolution processing element with channel-tile accumulation.
//
// Keeps a 3x3 sliding window of TIN-channel pixels. Column 0 is the oldest
// column and column 2 the newest. The block also holds a double-buffered
// filter bank (shadow/active). One i_cal_start launches one window through a
// four-stage pipeline:
//   S1 mask window + snapshot active filter
//   S2 TOUT*TIN*9 products
//   S3 per-lane sum
//   S4 accumulate
// o_vld is raised when the launch that carried acc_last finishes, 4 cycles
// after i_cal_start.
//
// Ports
//   clk, rstn           clock, asynchronous active-low reset
//   i_data_run          shift window, load i_ifm_col into column 2
//   i_cal_start         launch one window computation (shifts window, col 2 holds)
//   i_mode_1x1          1: only centre tap used; 0: 3x3 with padding masks
//   i_first/last_row    zero window row 0 / row 2 (3x3 only)
//   i_first/last_col    zero window column 0 / column 2 (3x3 only)
//   i_acc_first/last    first / last channel tile of the output pixel
//   i_ifm_col           new column, row r channel c at [(r*TIN+c)*W_DATA]
//   i_load_filter       write shadow bank for input channel i_load_idx
//   i_filter            weights, lane o tap t at [(o*9+t)*W_KERNEL]
//   i_swap_filter       copy shadow bank to active bank
//   o_acc               accumulators, lane o at [o*W_PSUM]
//   o_vld               one-cycle pulse when o_acc holds a finished pixel
module conv_pe_acc #(
  parameter  int TIN      = 4,
  parameter  int TOUT     = 4,
  parameter  int W_DATA   = 8,
  parameter  int W_KERNEL = 8,
  parameter  int W_PSUM   = 32,
  localparam int W_IDX    = (TIN > 1) ? $clog2(TIN) : 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          i_data_run,
  input  logic                          i_cal_start,
  input  logic                          i_mode_1x1,
  input  logic                          i_first_row,
  input  logic                          i_last_row,
  input  logic                          i_first_col,
  input  logic                          i_last_col,
  input  logic                          i_acc_first,
  input  logic                          i_acc_last,
  input  logic [3*TIN*W_DATA-1:0]       i_ifm_col,
  input  logic                          i_load_filter,
  input  logic [W_IDX-1:0]              i_load_idx,
  input  logic [TOUT*9*W_KERNEL-1:0]    i_filter,
  input  logic                          i_swap_filter,
  output logic [TOUT*W_PSUM-1:0]        o_acc,
  output logic                          o_vld
);

  localparam int W_PROD = W_DATA + W_KERNEL + 1;

  logic        [W_DATA-1:0]   r_win        [3][3][TIN];   // [row][col][ch]
  logic signed [W_KERNEL-1:0] r_flt_shadow [TIN][TOUT][9];
  logic signed [W_KERNEL-1:0] r_flt_active [TIN][TOUT][9];

  logic        [W_DATA-1:0]   w_win_masked [9][TIN];      // [tap][ch]

  logic        [W_DATA-1:0]   r_s1_win     [9][TIN];
  logic signed [W_KERNEL-1:0] r_s1_flt     [TIN][TOUT][9];
  logic                       r_s1_vld, r_s1_first, r_s1_last;

  logic signed [W_PROD-1:0]   r_s2_prod    [TOUT][TIN][9];
  logic                       r_s2_vld, r_s2_first, r_s2_last;

  logic signed [W_PSUM-1:0]   w_sum        [TOUT];
  logic signed [W_PSUM-1:0]   r_s3_sum     [TOUT];
  logic                       r_s3_vld, r_s3_first, r_s3_last;

  logic signed [W_PSUM-1:0]   r_acc        [TOUT];
  logic                       r_vld;

  // Pixel is unsigned, so it is zero-extended before the signed multiply.
  function automatic logic signed [W_PROD-1:0] mul_px(
    input logic        [W_DATA-1:0]   px,
    input logic signed [W_KERNEL-1:0] wt
  );
    logic signed [W_PROD-1:0] a;
    logic signed [W_PROD-1:0] b;
    a = $signed(W_PROD'(px));
    b = W_PROD'(wt);
    return a * b;
  endfunction

  function automatic logic tap_kept(
    input int   row,
    input int   col,
    input logic mode_1x1,
    input logic first_row,
    input logic last_row,
    input logic first_col,
    input logic last_col
  );
    if (mode_1x1)
      return (row == 1) && (col == 1);
    return !((first_row && row == 0) || (last_row && row == 2) ||
             (first_col && col == 0) || (last_col && col == 2));
  endfunction

  // Window: cal_start shifts as well, so back-to-back launches slide the window.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 3; k++)
          for (int c = 0; c < TIN; c++)
            r_win[r][k][c] <= '0;
    end else if (i_data_run || i_cal_start) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < TIN; c++) begin
          r_win[r][0][c] <= r_win[r][1][c];
          r_win[r][1][c] <= r_win[r][2][c];
          if (i_data_run)
            r_win[r][2][c] <= i_ifm_col[(r*TIN+c)*W_DATA +: W_DATA];
        end
    end
  end

  // Filter banks: a load and a swap in the same cycle move the old shadow
  // into active while the load lands in shadow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < TIN; c++)
        for (int o = 0; o < TOUT; o++)
          for (int t = 0; t < 9; t++) begin
            r_flt_shadow[c][o][t] <= '0;
            r_flt_active[c][o][t] <= '0;
          end
    end else begin
      if (i_load_filter)
        for (int o = 0; o < TOUT; o++)
          for (int t = 0; t < 9; t++)
            r_flt_shadow[i_load_idx][o][t] <= i_filter[(o*9+t)*W_KERNEL +: W_KERNEL];
      if (i_swap_filter)
        r_flt_active <= r_flt_shadow;
    end
  end

  // The 1x1 mode is consumed entirely by masking here, so it need not travel further.
  always_comb begin
    for (int t = 0; t < 9; t++)
      for (int c = 0; c < TIN; c++)
        w_win_masked[t][c] = '0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        if (tap_kept(r, k, i_mode_1x1, i_first_row, i_last_row, i_first_col, i_last_col))
          for (int c = 0; c < TIN; c++)
            w_win_masked[r*3+k][c] = r_win[r][k][c];
  end

  // S1
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      for (int t = 0; t < 9; t++)
        for (int c = 0; c < TIN; c++)
          r_s1_win[t][c] <= '0;
      for (int c = 0; c < TIN; c++)
        for (int o = 0; o < TOUT; o++)
          for (int t = 0; t < 9; t++)
            r_s1_flt[c][o][t] <= '0;
    end else begin
      r_s1_vld <= i_cal_start;
      if (i_cal_start) begin
        r_s1_first <= i_acc_first;
        r_s1_last  <= i_acc_last;
        r_s1_win   <= w_win_masked;
        r_s1_flt   <= r_flt_active;
      end
    end
  end

  // S2
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s2_vld   <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
      for (int o = 0; o < TOUT; o++)
        for (int c = 0; c < TIN; c++)
          for (int t = 0; t < 9; t++)
            r_s2_prod[o][c][t] <= '0;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_first <= r_s1_first;
        r_s2_last  <= r_s1_last;
        for (int o = 0; o < TOUT; o++)
          for (int c = 0; c < TIN; c++)
            for (int t = 0; t < 9; t++)
              r_s2_prod[o][c][t] <= mul_px(r_s1_win[t][c], r_s1_flt[c][o][t]);
      end
    end
  end

  always_comb begin
    for (int o = 0; o < TOUT; o++) begin
      w_sum[o] = '0;
      for (int c = 0; c < TIN; c++)
        for (int t = 0; t < 9; t++)
          w_sum[o] = w_sum[o] + W_PSUM'(r_s2_prod[o][c][t]);
    end
  end

  // S3
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s3_vld   <= 1'b0;
      r_s3_first <= 1'b0;
      r_s3_last  <= 1'b0;
      for (int o = 0; o < TOUT; o++)
        r_s3_sum[o] <= '0;
    end else begin
      r_s3_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_s3_first <= r_s2_first;
        r_s3_last  <= r_s2_last;
        r_s3_sum   <= w_sum;
      end
    end
  end

  // S4: wraps modulo 2^W_PSUM. A non-first tile with no prior first simply
  // adds onto whatever the register holds.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld <= 1'b0;
      for (int o = 0; o < TOUT; o++)
        r_acc[o] <= '0;
    end else begin
      r_vld <= r_s3_vld && r_s3_last;
      if (r_s3_vld)
        for (int o = 0; o < TOUT; o++)
          r_acc[o] <= r_s3_first ? r_s3_sum[o] : r_acc[o] + r_s3_sum[o];
    end
  end

  always_comb begin
    o_acc = '0;
    for (int o = 0; o < TOUT; o++)
      o_acc[o*W_PSUM +: W_PSUM] = r_acc[o];
  end

  assign o_vld = r_vld;

endmodule
